// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit multiplexed 7-segment scanner with frame-synchronous
// double-buffered pattern load, per-digit blink, blanking and pattern-to-BCD decode.
module seg_scan_driver #(
   parameter int REFRESH_DIV    = 50000,
   parameter int BLINK_FRAMES   = 64,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [27:0] seg_in,
   input  logic        load,
   output logic        load_ack,
   input  logic        blank,
   input  logic [3:0]  blink_mask,
   output logic [6:0]  seg_out,
   output logic [3:0]  an,
   output logic [1:0]  digit_idx,
   output logic [3:0]  dec_digit,
   output logic        dec_err,
   output logic        frame_done
);
   localparam int CW = $clog2(REFRESH_DIV);
   localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    digit_q, digit_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          phase_q, phase_d;
   logic [27:0]   active_q, active_d, shadow_q, shadow_d;
   logic          pending_q, pending_d;
   logic          ack_q, ack_d, fdone_q, fdone_d;
   logic [6:0]    seg_q, seg_d;
   logic [3:0]    an_q, an_d, dig_q, dig_d;
   logic          err_q, err_d;
   logic          tc, bnd, fwrap, dark;
   logic [1:0]    slot;
   logic [6:0]    pat;

   always_comb begin
      tc        = cnt_q == CW'(REFRESH_DIV - 1);
      bnd       = tc && digit_q == 2'd3;
      fwrap     = fcnt_q == FW'(BLINK_FRAMES - 1);
      cnt_d     = tc ? '0 : cnt_q + 1'b1;
      digit_d   = tc ? digit_q + 2'd1 : digit_q;
      fcnt_d    = bnd ? (fwrap ? '0 : fcnt_q + 1'b1) : fcnt_q;
      phase_d   = phase_q ^ (bnd && fwrap);
      shadow_d  = load ? seg_in : shadow_q;
      pending_d = !bnd && (load || pending_q);
      // A load landing on the boundary bypasses the shadow so it shows next frame
      active_d  = (bnd && load) ? seg_in : (bnd && pending_q) ? shadow_q : active_q;
      ack_d     = bnd && (load || pending_q);
      fdone_d   = bnd;
      slot      = ~digit_q;
      pat       = active_q[7*slot +: 7];
      dark      = blank || (phase_q && blink_mask[slot]);
      seg_d     = dark ? 7'h00 : pat;
      an_d      = dark ? 4'h0 : 4'b1000 >> digit_q;
      dig_d     = 4'hF;
      err_d     = 1'b0;
      case (pat)
         7'h3F: dig_d = 4'd0;
         7'h06: dig_d = 4'd1;
         7'h5B: dig_d = 4'd2;
         7'h4F: dig_d = 4'd3;
         7'h66: dig_d = 4'd4;
         7'h6D: dig_d = 4'd5;
         7'h7D: dig_d = 4'd6;
         7'h07: dig_d = 4'd7;
         7'h7F: dig_d = 4'd8;
         7'h6F: dig_d = 4'd9;
         7'h00: ;
         default: err_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q     <= '0;
         digit_q   <= '0;
         fcnt_q    <= '0;
         phase_q   <= 1'b0;
         active_q  <= '0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
         ack_q     <= 1'b0;
         fdone_q   <= 1'b0;
         seg_q     <= '0;
         an_q      <= '0;
         dig_q     <= 4'hF;
         err_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         digit_q   <= digit_d;
         fcnt_q    <= fcnt_d;
         phase_q   <= phase_d;
         active_q  <= active_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         ack_q     <= ack_d;
         fdone_q   <= fdone_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
         dig_q     <= dig_d;
         err_q     <= err_d;
      end
   end

   assign seg_out    = SEG_ACTIVE_LOW != 0 ? ~seg_q : seg_q;
   assign an         = AN_ACTIVE_LOW != 0 ? ~an_q : an_q;
   assign digit_idx  = digit_q;
   assign dec_digit  = dig_q;
   assign dec_err    = err_q;
   assign load_ack   = ack_q;
   assign frame_done = fdone_q;
endmodule
